cpu_design_project: RTL and testbench
=====================================

// Module: cpu_design_project
// PURPOSE
//  Single-bus 32-bit CPU datapath slice: bus multiplexer, GPRs R1-R3, PC, IR, MDR, MAR, Y, ZLow and a small ALU.
//  All control strobes come from an external control unit, or from a bench during bring-up.
//  The bus value is exported for observation. This block is the core datapath that the later control-unit phase drives.
// PARAMETERS
//  WIDTH  32  datapath/register width (the only supported value is 32)
// PORTS
//  Clock            in   1   system clock; all registers update on its rising edge
//  Resetn           in   1   asynchronous, active-low reset
//  PCout,Zlowout,MDRout,R1out,R2out,R3out  in  1 each  bus-source selects
//  MARin,ZLowIn,PCin,MDRin,IRin,Yin        in  1 each  register load enables
//  R1in,R2in,R3in   in   1   GPR load enables
//  IncPC            in   1   ALU forced to (bus + 1); ZLow loads this result
//  Read             in   1   MDR input mux: 1 = Mdatain, 0 = bus
//  AND              in   5   ALU operation select (encoding below)
//  Mdatain          in   32  memory read data
//  BusMuxOut_output out  32  current bus value (combinational)
// BEHAVIOUR
//  - Reset (Resetn=0, asynchronous): PC, IR, MDR, MAR, Y, ZLow, R1, R2 and R3 all clear to 0 immediately.
//    BusMuxOut_output = 0 while no out-select is high.
//  - Bus: combinational mux. Fixed priority when several selects are high: PCout > Zlowout > MDRout > R1out > R2out > R3out.
//    No select high -> bus = 32'h0.
//  - Register load: every register loads on a rising Clock edge when its enable is high, otherwise it holds.
//    Enables are level-sampled at the edge. A register reads the bus value present before the edge.
//  - MDR: D = Read ? Mdatain : bus. Loads when MDRin=1; Read alone does not load MDR.
//  - ALU: combinational, A = Y, B = bus. AND[4:0] encoding:
//    00=ADD A+B, 01=AND A&B, 02=OR A|B, 03=SUB A-B, 04=XOR A^B, 05=NOT ~B, 06=NEG -B.
//    Any other code gives result 0. Arithmetic is mod 2^32; carry and borrow are discarded.
//  - IncPC=1 overrides AND: result = bus + 1.
//  - ZLow loads the ALU result on a rising edge when (ZLowIn | IncPC) is high.
//  - PC loads from the bus on PCin. PC has no self-increment path; increment is only PC -> bus -> ALU(+1) -> ZLow -> PC.
//  - MAR and IR load from the bus on MARin/IRin. Their values are internal; no address or IR port.
//  - Simultaneous load and bus drive of the same register (e.g. Zlowout+ZLowIn): the register gets the value computed
//    from its old contents, i.e. normal edge semantics, no combinational loop through the register.
//  - Resetn deasserted mid-sequence: registers restart from 0. No state machine exists inside this block; it is pure datapath.
//  - Single-cycle latency for every transfer. Fetch takes 3 cycles:
//    T0 (PCout, MARin, IncPC), T1 (Zlowout, PCin, Read, MDRin), T2 (MDRout, IRin).
// STRUCTURE
//  - Shared package cpu_pkg: WIDTH constant and the ALU op localparams (ALU_ADD .. ALU_NEG).
//  - One sub-module, reg32: 32-bit register with Clock, Resetn and enable, instantiated for every register.
//  - Bus mux, MDR input mux and ALU are inline in cpu_design_project.
// TESTING
//  - Reset: Resetn=0 mid-run -> all registers 0 asynchronously; bus 0 with no selects high.
//  - Register load: Mdatain=0x12, Read+MDRin for one edge, then MDRout+R2in -> R2=0x12.
//    Likewise R3=0x14 and R1=0x18; bus shows each value while MDRout is high.
//  - Fetch: PC=0; T0 -> MAR=0 and ZLow=1. T1 with Mdatain=0x28918000 -> PC=1, MDR=0x28918000.
//    T2 -> IR=0x28918000.
//  - AND: R2out+Yin -> Y=0x12. R3out, AND=1, ZLowIn -> ZLow=0x10. Zlowout+R1in -> R1=0x10, bus=0x10.
//  - ALU sweep with Y=0x12 and bus=0x14:
//    ADD->0x26, OR->0x16, SUB->0xFFFFFFFE, XOR->0x06, NOT->0xFFFFFFEB, NEG->0xFFFFFFEC, code 31->0.
//  - Bus priority: PCout and R1out high together -> bus = PC. No selects high -> bus = 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
//   Constants shared by the CPU datapath slice: the datapath width and the
//   ALU operation codes carried on the 5-bit AND select of cpu_design_project.
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int WIDTH = 32;

    localparam logic [4:0] ALU_ADD = 5'd0;  // A + B
    localparam logic [4:0] ALU_AND = 5'd1;  // A & B
    localparam logic [4:0] ALU_OR  = 5'd2;  // A | B
    localparam logic [4:0] ALU_SUB = 5'd3;  // A - B
    localparam logic [4:0] ALU_XOR = 5'd4;  // A ^ B
    localparam logic [4:0] ALU_NOT = 5'd5;  // ~B
    localparam logic [4:0] ALU_NEG = 5'd6;  // -B

endpackage

// File: rtl/reg32.sv
// ----------------------------------------------------------------------------
// reg32
//   WIDTH-bit register with load enable; holds when en is low.
// Ports
//   Clock   in   1      rising-edge clock
//   Resetn  in   1      asynchronous active-low clear
//   en      in   1      load enable, sampled at the rising edge
//   d       in   WIDTH  next value
//   q       out  WIDTH  registered value
// ----------------------------------------------------------------------------
module reg32
    import cpu_pkg::*;
(
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking assignment so every register
    // in the datapath samples the pre-edge bus value, independent of the
    // order in which the simulator evaluates the instances.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/cpu_design_project.sv
// ----------------------------------------------------------------------------
// cpu_design_project
//   Single-bus 32-bit CPU datapath slice. One shared bus is driven by the
//   selected source register; PC, IR, MAR, MDR, Y, ZLow and R1-R3 load from
//   it (MDR optionally from memory data, ZLow from the ALU). The ALU takes
//   A from Y and B from the bus. All strobes come from outside; there is no
//   internal sequencing.
// Ports
//   Clock, Resetn                          clock / async active-low reset
//   PCout, Zlowout, MDRout, R1out..R3out   bus source selects (priority in
//                                          that order)
//   MARin, ZLowIn, PCin, MDRin, IRin, Yin  register load enables
//   R1in, R2in, R3in                       GPR load enables
//   IncPC                                  ALU result forced to bus + 1 and
//                                          ZLow load forced
//   Read                                   MDR source: 1 = Mdatain, 0 = bus
//   AND[4:0]                               ALU operation (cpu_pkg ALU_*)
//   Mdatain[31:0]                          memory read data
//   BusMuxOut_output[31:0]                 current bus value
// ----------------------------------------------------------------------------
module cpu_design_project
    import cpu_pkg::*;
(
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             PCout,
    input  logic             Zlowout,
    input  logic             MDRout,
    input  logic             R1out,
    input  logic             R2out,
    input  logic             R3out,
    input  logic             MARin,
    input  logic             ZLowIn,
    input  logic             PCin,
    input  logic             MDRin,
    input  logic             IRin,
    input  logic             Yin,
    input  logic             R1in,
    input  logic             R2in,
    input  logic             R3in,
    input  logic             IncPC,
    input  logic             Read,
    input  logic [4:0]       AND,
    input  logic [WIDTH-1:0] Mdatain,
    output logic [WIDTH-1:0] BusMuxOut_output
);

    logic [WIDTH-1:0] bus;
    logic [WIDTH-1:0] pc, ir, mar, mdr, y, zlow, r1, r2, r3;
    logic [WIDTH-1:0] mdr_d;
    logic [WIDTH-1:0] alu_result;

    // ---------------------------------------------------------------------
    // Bus multiplexer: fixed priority, zero when nothing drives.
    // ---------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which is what would otherwise infer a latch.
    always_comb begin
        bus = '0;
        if (PCout)        bus = pc;
        else if (Zlowout) bus = zlow;
        else if (MDRout)  bus = mdr;
        else if (R1out)   bus = r1;
        else if (R2out)   bus = r2;
        else if (R3out)   bus = r3;
    end

    assign BusMuxOut_output = bus;

    // MDR takes memory data during a read, otherwise the bus.
    assign mdr_d = Read ? Mdatain : bus;

    // ---------------------------------------------------------------------
    // ALU: A = Y, B = bus. IncPC overrides the operation select.
    // ---------------------------------------------------------------------
    always_comb begin
        alu_result = '0;
        if (IncPC) begin
            alu_result = bus + WIDTH'(1);
        end else begin
            case (AND)
                ALU_ADD: alu_result = y + bus;
                ALU_AND: alu_result = y & bus;
                ALU_OR:  alu_result = y | bus;
                ALU_SUB: alu_result = y - bus;
                ALU_XOR: alu_result = y ^ bus;
                ALU_NOT: alu_result = ~bus;
                ALU_NEG: alu_result = -bus;
                default: alu_result = '0;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Registers. A register that both drives and loads the bus in one cycle
    // simply captures a value derived from its old contents.
    // ---------------------------------------------------------------------
    reg32 u_pc   (.Clock(Clock), .Resetn(Resetn), .en(PCin),           .d(bus),        .q(pc));
    reg32 u_ir   (.Clock(Clock), .Resetn(Resetn), .en(IRin),           .d(bus),        .q(ir));
    reg32 u_mar  (.Clock(Clock), .Resetn(Resetn), .en(MARin),          .d(bus),        .q(mar));
    reg32 u_mdr  (.Clock(Clock), .Resetn(Resetn), .en(MDRin),          .d(mdr_d),      .q(mdr));
    reg32 u_y    (.Clock(Clock), .Resetn(Resetn), .en(Yin),            .d(bus),        .q(y));
    reg32 u_zlow (.Clock(Clock), .Resetn(Resetn), .en(ZLowIn | IncPC), .d(alu_result), .q(zlow));
    reg32 u_r1   (.Clock(Clock), .Resetn(Resetn), .en(R1in),           .d(bus),        .q(r1));
    reg32 u_r2   (.Clock(Clock), .Resetn(Resetn), .en(R2in),           .d(bus),        .q(r2));
    reg32 u_r3   (.Clock(Clock), .Resetn(Resetn), .en(R3in),           .d(bus),        .q(r3));

    // MAR and IR feed the memory interface and decoder of the later control
    // phase; in this slice nothing consumes them yet.
    logic unused_ok;
    assign unused_ok = ^{mar, ir};

endmodule

// File: tb/tb_cpu_design_project.sv
// ----------------------------------------------------------------------------
// tb_cpu_design_project
//   Directed bench for the datapath slice. Register contents are observed by
//   routing them onto the bus; MAR and IR, which never reach the bus, are
//   observed hierarchically.
// ----------------------------------------------------------------------------
module tb_cpu_design_project;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        PCout, Zlowout, MDRout, R1out, R2out, R3out;
    logic        MARin, ZLowIn, PCin, MDRin, IRin, Yin;
    logic        R1in, R2in, R3in;
    logic        IncPC, Read;
    logic [4:0]  AND;
    logic [31:0] Mdatain;
    logic [31:0] BusMuxOut_output;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_design_project dut (
        .Clock(Clock), .Resetn(Resetn),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout),
        .R1out(R1out), .R2out(R2out), .R3out(R3out),
        .MARin(MARin), .ZLowIn(ZLowIn), .PCin(PCin), .MDRin(MDRin),
        .IRin(IRin), .Yin(Yin), .R1in(R1in), .R2in(R2in), .R3in(R3in),
        .IncPC(IncPC), .Read(Read), .AND(AND), .Mdatain(Mdatain),
        .BusMuxOut_output(BusMuxOut_output)
    );

    always #5 Clock = ~Clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic clear_ctrl();
        PCout = 0; Zlowout = 0; MDRout = 0; R1out = 0; R2out = 0; R3out = 0;
        MARin = 0; ZLowIn = 0; PCin = 0; MDRin = 0; IRin = 0; Yin = 0;
        R1in = 0; R2in = 0; R3in = 0; IncPC = 0; Read = 0; AND = 5'd0;
    endtask

    // One rising edge, then settle 1 time unit past it and drop all strobes.
    task automatic tick();
        @(posedge Clock);
        #1;
        clear_ctrl();
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        clear_ctrl();
        Mdatain = 32'h0;
        repeat (2) @(posedge Clock);
        #1;
        n_checks++;
        if (BusMuxOut_output !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_bus_idle: got %h expected %h", BusMuxOut_output, 32'h0);
        end
        n_checks++;
        if ({dut.pc, dut.ir, dut.mar, dut.mdr, dut.y, dut.zlow, dut.r1, dut.r2, dut.r3} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: some register nonzero (pc %h mdr %h zlow %h)",
                     dut.pc, dut.mdr, dut.zlow);
        end
        Resetn = 1'b1;
        #2;
    endtask

    task automatic test_register_load();
        logic [31:0] vals [3] = '{32'h12, 32'h14, 32'h18};
        for (int i = 0; i < 3; i++) begin
            Mdatain = vals[i];
            Read = 1; MDRin = 1;
            tick();
            MDRout = 1;
            #1;
            n_checks++;
            if (BusMuxOut_output !== vals[i]) begin
                n_fail++;
                $display("FAIL load_mdr_bus_%0d: got %h expected %h", i, BusMuxOut_output, vals[i]);
            end
            if (i == 0) R2in = 1;
            else if (i == 1) R3in = 1;
            else R1in = 1;
            tick();
        end
        // Read without MDRin must leave MDR alone.
        Mdatain = 32'h99; Read = 1;
        tick();
        MDRout = 1; #1;
        n_checks++;
        if (BusMuxOut_output !== 32'h18) begin
            n_fail++;
            $display("FAIL read_alone_no_load: got %h expected %h", BusMuxOut_output, 32'h18);
        end
        clear_ctrl();
        R1out = 1; #1;
        n_checks++;
        if (BusMuxOut_output !== 32'h18) begin
            n_fail++;
            $display("FAIL r1_value: got %h expected %h", BusMuxOut_output, 32'h18);
        end
        clear_ctrl(); R2out = 1; #1;
        n_checks++;
        if (BusMuxOut_output !== 32'h12) begin
            n_fail++;
            $display("FAIL r2_value: got %h expected %h", BusMuxOut_output, 32'h12);
        end
        clear_ctrl(); R3out = 1; #1;
        n_checks++;
        if (BusMuxOut_output !== 32'h14) begin
            n_fail++;
            $display("FAIL r3_value: got %h expected %h", BusMuxOut_output, 32'h14);
        end
        clear_ctrl();
    endtask

    task automatic test_fetch();
        // T0: PC (0) -> MAR, ZLow = PC + 1
        PCout = 1; MARin = 1; IncPC = 1;
        tick();
        n_checks++;
        if (dut.mar !== 32'h0) begin
            n_fail++;
            $display("FAIL fetch_t0_mar: got %h expected %h", dut.mar, 32'h0);
        end
        Zlowout = 1; #1;
        n_checks++;
        if (BusMuxOut_output !== 32'h1) begin
            n_fail++;
            $display("FAIL fetch_t0_zlow: got %h expected %h", BusMuxOut_output, 32'h1);
        end
        // T1: ZLow -> PC, memory -> MDR
        Mdatain = 32'h28918000;
        Zlowout = 1; PCin = 1; Read = 1; MDRin = 1;
        tick();
        PCout = 1; #1;
        n_checks++;
        if (BusMuxOut_output !== 32'h1) begin
            n_fail++;
            $display("FAIL fetch_t1_pc: got %h expected %h", BusMuxOut_output, 32'h1);
        end
        clear_ctrl(); MDRout = 1; #1;
        n_checks++;
        if (BusMuxOut_output !== 32'h28918000) begin
            n_fail++;
            $display("FAIL fetch_t1_mdr: got %h expected %h", BusMuxOut_output, 32'h28918000);
        end
        // T2: MDR -> IR
        IRin = 1;
        tick();
        n_checks++;
        if (dut.ir !== 32'h28918000) begin
            n_fail++;
            $display("FAIL fetch_t2_ir: got %h expected %h", dut.ir, 32'h28918000);
        end
    endtask

    task automatic test_and();
        R2out = 1; Yin = 1;
        tick();
        R3out = 1; AND = 5'd1; ZLowIn = 1;
        tick();
        Zlowout = 1; #1;
        n_checks++;
        if (BusMuxOut_output !== 32'h10) begin
            n_fail++;
            $display("FAIL and_zlow_bus: got %h expected %h", BusMuxOut_output, 32'h10);
        end
        R1in = 1;
        tick();
        R1out = 1; #1;
        n_checks++;
        if (BusMuxOut_output !== 32'h10) begin
            n_fail++;
            $display("FAIL and_r1: got %h expected %h", BusMuxOut_output, 32'h10);
        end
        clear_ctrl();
    endtask

    // Y = 0x12 (from test_and), bus = R3 = 0x14.
    task automatic test_alu_sweep();
        logic [4:0]  ops [9] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd31};
        logic [31:0] exps[9] = '{32'h26, 32'h10, 32'h16, 32'hFFFFFFFE, 32'h06,
                                 32'hFFFFFFEB, 32'hFFFFFFEC, 32'h0, 32'h0};
        for (int i = 0; i < 9; i++) begin
            R3out = 1; AND = ops[i]; ZLowIn = 1;
            tick();
            Zlowout = 1; #1;
            n_checks++;
            if (BusMuxOut_output !== exps[i]) begin
                n_fail++;
                $display("FAIL alu_op_%0d: got %h expected %h", ops[i], BusMuxOut_output, exps[i]);
            end
            clear_ctrl();
        end
        // IncPC overrides a SUB select and loads ZLow without ZLowIn.
        R3out = 1; AND = 5'd3; IncPC = 1;
        tick();
        Zlowout = 1; #1;
        n_checks++;
        if (BusMuxOut_output !== 32'h15) begin
            n_fail++;
            $display("FAIL incpc_override: got %h expected %h", BusMuxOut_output, 32'h15);
        end
        // ZLow drives and loads together: new = Y + old = 0x12 + 0x15.
        Zlowout = 1; ZLowIn = 1; AND = 5'd0;
        tick();
        Zlowout = 1; #1;
        n_checks++;
        if (BusMuxOut_output !== 32'h27) begin
            n_fail++;
            $display("FAIL zlow_self_loop: got %h expected %h", BusMuxOut_output, 32'h27);
        end
        clear_ctrl();
    endtask

    // PC = 1, ZLow = 0x27, MDR = 0x28918000, R1 = 0x10, R2 = 0x12, R3 = 0x14.
    task automatic test_bus_priority();
        PCout = 1; R1out = 1; #1;
        n_checks++;
        if (BusMuxOut_output !== 32'h1) begin
            n_fail++;
            $display("FAIL prio_pc_r1: got %h expected %h", BusMuxOut_output, 32'h1);
        end
        clear_ctrl(); Zlowout = 1; MDRout = 1; R3out = 1; #1;
        n_checks++;
        if (BusMuxOut_output !== 32'h27) begin
            n_fail++;
            $display("FAIL prio_zlow_mdr: got %h expected %h", BusMuxOut_output, 32'h27);
        end
        clear_ctrl(); MDRout = 1; R1out = 1; #1;
        n_checks++;
        if (BusMuxOut_output !== 32'h28918000) begin
            n_fail++;
            $display("FAIL prio_mdr_r1: got %h expected %h", BusMuxOut_output, 32'h28918000);
        end
        clear_ctrl(); R2out = 1; R3out = 1; #1;
        n_checks++;
        if (BusMuxOut_output !== 32'h12) begin
            n_fail++;
            $display("FAIL prio_r2_r3: got %h expected %h", BusMuxOut_output, 32'h12);
        end
        clear_ctrl(); #1;
        n_checks++;
        if (BusMuxOut_output !== 32'h0) begin
            n_fail++;
            $display("FAIL bus_idle: got %h expected %h", BusMuxOut_output, 32'h0);
        end
    endtask

    task automatic test_reset_midrun();
        // Assert reset between edges: clear must be immediate.
        @(negedge Clock);
        #2;
        Resetn = 1'b0;
        #1;
        n_checks++;
        if ({dut.pc, dut.ir, dut.mar, dut.mdr, dut.y, dut.zlow, dut.r1, dut.r2, dut.r3} !== '0) begin
            n_fail++;
            $display("FAIL midrun_async_clear: pc %h ir %h mdr %h zlow %h r1 %h",
                     dut.pc, dut.ir, dut.mdr, dut.zlow, dut.r1);
        end
        PCout = 1; R1out = 1; #1;
        n_checks++;
        if (BusMuxOut_output !== 32'h0) begin
            n_fail++;
            $display("FAIL midrun_bus: got %h expected %h", BusMuxOut_output, 32'h0);
        end
        clear_ctrl();
        @(negedge Clock);
        Resetn = 1'b1;
        // Restart: fetch-style increment from PC = 0 again.
        PCout = 1; IncPC = 1;
        tick();
        Zlowout = 1; #1;
        n_checks++;
        if (BusMuxOut_output !== 32'h1) begin
            n_fail++;
            $display("FAIL restart_incpc: got %h expected %h", BusMuxOut_output, 32'h1);
        end
        clear_ctrl();
    endtask

    initial begin
        test_reset();
        test_register_load();
        test_fetch();
        test_and();
        test_alu_sweep();
        test_bus_priority();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
